user_ram_arbiter: RTL and testbench

Shares the single-port user-record RAM (fields pass 16 b, admin 1 b, lock 1 b, count 4 b; 12-bit address) between two requesters: the keypad manager FSM (full-record reads/writes) and the login-attempt tracker (failed/successful-login read-modify-write of count/lock). It sits between the manager and the RAM, owns every RAM control line, and serializes all accesses so that no requester ever sees a half-updated record.

---
 rtl/user_ram_pkg.sv | 14 +
 rtl/user_ram_arbiter_if.sv | 38 +++
 rtl/rr_arb2.sv | 19 +
 rtl/user_ram_arbiter.sv | 119 +++++++++++
 tb/tb_user_ram_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/user_ram_pkg.sv
// user_ram_pkg: shared types and widths for the user-record RAM arbiter
// Contents: FSM state enum, field widths, RAM rw encodings, saturating count increment.
package user_ram_pkg;
  localparam int ADDR_W = 12;
  localparam int PASS_W = 16;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;
  localparam logic RW_READ = 1'b0;
  localparam logic RW_WRITE = 1'b1;
  typedef enum logic [2:0] {IDLE, M_ACC, M_DONE, F_RD, F_WR, F_DONE} state_t;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction
endpackage

// File: rtl/user_ram_arbiter_if.sv
// user_ram_arbiter_if: manager, tracker and RAM signal bundle for user_ram_arbiter
// Modports: slave = the arbiter, master = requesters plus RAM environment.
interface user_ram_arbiter_if;
  import user_ram_pkg::*;
  logic m_req, m_we, m_admin_w, m_lock_w;
  logic [ADDR_W-1:0] m_addr;
  logic [PASS_W-1:0] m_pass_w;
  logic [CNT_W-1:0] m_count_w;
  logic m_done, m_admin_r, m_lock_r;
  logic [PASS_W-1:0] m_pass_r;
  logic [CNT_W-1:0] m_count_r;
  logic f_req, f_clear, f_done, f_locked;
  logic [ADDR_W-1:0] f_addr;
  logic [CNT_W-1:0] f_count;
  logic cs, pass_rw, admin_rw, lock_rw, count_rw;
  logic [ADDR_W-1:0] addr;
  logic [PASS_W-1:0] pass_in, pass_out;
  logic admin_in, lock_in, admin_out, lock_out;
  logic [CNT_W-1:0] count_in, count_out;
  modport slave (
    input m_req, m_we, m_addr, m_pass_w, m_admin_w, m_lock_w, m_count_w,
    input f_req, f_clear, f_addr,
    input pass_out, admin_out, lock_out, count_out,
    output m_done, m_pass_r, m_admin_r, m_lock_r, m_count_r,
    output f_done, f_locked, f_count,
    output cs, pass_rw, admin_rw, lock_rw, count_rw, addr,
    output pass_in, admin_in, lock_in, count_in
  );
  modport master (
    output m_req, m_we, m_addr, m_pass_w, m_admin_w, m_lock_w, m_count_w,
    output f_req, f_clear, f_addr,
    output pass_out, admin_out, lock_out, count_out,
    input m_done, m_pass_r, m_admin_r, m_lock_r, m_count_r,
    input f_done, f_locked, f_count,
    input cs, pass_rw, admin_rw, lock_rw, count_rw, addr,
    input pass_in, admin_in, lock_in, count_in
  );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with one-hot grant
// Ports: clk, rst (sync active-low), req_i[1:0], advance_i (commit grant to pointer), gnt_o[1:0].
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);
  // last_q = 1 means requester 1 won last, so requester 0 wins a tie
  logic last_q, last_d;
  assign gnt_o[0] = req_i[0] & (~req_i[1] | last_q);
  assign gnt_o[1] = req_i[1] & (~req_i[0] | ~last_q);
  assign last_d = (advance_i && |req_i) ? gnt_o[1] : last_q;
  always_ff @(posedge clk) begin
    if (!rst) last_q <= 1'b1;
    else last_q <= last_d;
  end
endmodule

// File: rtl/user_ram_arbiter.sv
// user_ram_arbiter: serializes manager record accesses and tracker count/lock RMW onto one RAM port
// Ports: clk, rst (sync active-low), bus (user_ram_arbiter_if.slave: manager, tracker, RAM sides).
module user_ram_arbiter
  import user_ram_pkg::*;
#(
  parameter int MAX_TRIES = 3
) (
  input logic clk,
  input logic rst,
  user_ram_arbiter_if.slave bus
);
  localparam logic [CNT_W-1:0] TRIES = CNT_W'(MAX_TRIES);
  state_t state_q, state_d;
  logic [1:0] gnt;
  logic idle;
  logic we_q, clear_q, admin_q, lock_q, f_locked_q, new_lock;
  logic [ADDR_W-1:0] addr_q;
  logic [PASS_W-1:0] pass_q;
  logic [CNT_W-1:0] count_q, f_count_q, inc_count, new_count;
  logic cs, pass_rw, admin_rw, lock_rw, count_rw, m_done, f_done, m_rd;
  assign idle = state_q == IDLE;
  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     ({bus.f_req, bus.m_req}),
    .advance_i (idle),
    .gnt_o     (gnt)
  );
  always_comb begin
    state_d = state_q;
    cs = 1'b0;
    pass_rw = RW_READ;
    admin_rw = RW_READ;
    lock_rw = RW_READ;
    count_rw = RW_READ;
    m_done = 1'b0;
    f_done = 1'b0;
    case (state_q)
      IDLE: state_d = gnt[0] ? M_ACC : (gnt[1] ? F_RD : IDLE);
      M_ACC: begin
        cs = 1'b1;
        {pass_rw, admin_rw, lock_rw, count_rw} = {4{we_q ? RW_WRITE : RW_READ}};
        state_d = M_DONE;
      end
      M_DONE: begin
        m_done = 1'b1;
        state_d = IDLE;
      end
      F_RD: begin
        cs = 1'b1;
        state_d = F_WR;
      end
      F_WR: begin
        cs = 1'b1;
        lock_rw = RW_WRITE;
        count_rw = RW_WRITE;
        state_d = F_DONE;
      end
      F_DONE: begin
        f_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // RAM read data from F_RD is on the outputs during F_WR; a locked record keeps its count on success
  assign inc_count = sat_inc(bus.count_out);
  assign new_count = clear_q ? (bus.lock_out ? bus.count_out : '0) : inc_count;
  assign new_lock = clear_q ? bus.lock_out : (bus.lock_out | (inc_count >= TRIES));
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      clear_q <= 1'b0;
      addr_q <= '0;
      pass_q <= '0;
      admin_q <= 1'b0;
      lock_q <= 1'b0;
      count_q <= '0;
      f_count_q <= '0;
      f_locked_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (idle && |gnt) begin
        addr_q <= gnt[0] ? bus.m_addr : bus.f_addr;
        we_q <= gnt[0] & bus.m_we;
        clear_q <= bus.f_clear;
        pass_q <= bus.m_pass_w;
        admin_q <= bus.m_admin_w;
        lock_q <= bus.m_lock_w;
        count_q <= bus.m_count_w;
      end
      if (state_q == F_WR) begin
        f_count_q <= new_count;
        f_locked_q <= new_lock;
      end
    end
  end
  // RAM controls are gated by reset so a cut operation never writes
  assign bus.cs = cs & rst;
  assign bus.pass_rw = pass_rw & rst;
  assign bus.admin_rw = admin_rw & rst;
  assign bus.lock_rw = lock_rw & rst;
  assign bus.count_rw = count_rw & rst;
  assign bus.addr = (cs & rst) ? addr_q : '0;
  assign bus.pass_in = (pass_rw & rst) ? pass_q : '0;
  assign bus.admin_in = (admin_rw & rst) ? admin_q : 1'b0;
  assign bus.lock_in = (lock_rw & rst) ? ((state_q == F_WR) ? new_lock : lock_q) : 1'b0;
  assign bus.count_in = (count_rw & rst) ? ((state_q == F_WR) ? new_count : count_q) : '0;
  assign m_rd = m_done & rst & ~we_q;
  assign bus.m_done = m_done & rst;
  assign bus.m_pass_r = m_rd ? bus.pass_out : '0;
  assign bus.m_admin_r = m_rd ? bus.admin_out : 1'b0;
  assign bus.m_lock_r = m_rd ? bus.lock_out : 1'b0;
  assign bus.m_count_r = m_rd ? bus.count_out : '0;
  assign bus.f_done = f_done & rst;
  assign bus.f_count = f_count_q;
  assign bus.f_locked = f_locked_q;
endmodule

// File: tb/tb_user_ram_arbiter.sv
// tb_user_ram_arbiter: randomized self-checking bench with a RAM model and a record-level reference
module tb_user_ram_arbiter;
  localparam int TRIES = 3;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  user_ram_arbiter_if bus ();
  user_ram_arbiter #(.MAX_TRIES(TRIES)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [15:0] mem_pass [4096] = '{default: '0};
  logic mem_admin [4096] = '{default: 1'b0};
  logic mem_lock [4096] = '{default: 1'b0};
  logic [3:0] mem_cnt [4096] = '{default: '0};
  logic [15:0] ref_pass [4096] = '{default: '0};
  logic ref_admin [4096] = '{default: 1'b0};
  logic ref_lock [4096] = '{default: 1'b0};
  logic [3:0] ref_cnt [4096] = '{default: '0};
  int n_vec = 0;
  int n_err = 0;
  bit last_m = 1'b0;
  always @(posedge clk) begin
    if (bus.cs) begin
      if (bus.pass_rw) mem_pass[bus.addr] <= bus.pass_in;
      else bus.pass_out <= mem_pass[bus.addr];
      if (bus.admin_rw) mem_admin[bus.addr] <= bus.admin_in;
      else bus.admin_out <= mem_admin[bus.addr];
      if (bus.lock_rw) mem_lock[bus.addr] <= bus.lock_in;
      else bus.lock_out <= mem_lock[bus.addr];
      if (bus.count_rw) mem_cnt[bus.addr] <= bus.count_in;
      else bus.count_out <= mem_cnt[bus.addr];
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic f_model(input bit clr, input logic [11:0] a, output logic [3:0] c, output logic l);
    int n;
    if (!clr) begin
      n = int'(ref_cnt[a]) + 1;
      if (n > 15) n = 15;
      c = 4'(n);
      l = ref_lock[a] || (n >= TRIES);
    end else if (ref_lock[a]) begin
      c = ref_cnt[a];
      l = 1'b1;
    end else begin
      c = 4'd0;
      l = 1'b0;
    end
    ref_cnt[a] = c;
    ref_lock[a] = l;
  endtask
  task automatic check_read(input string tag, input logic [11:0] a);
    check({tag, "_pass"}, 64'(bus.m_pass_r), 64'(ref_pass[a]));
    check({tag, "_admin"}, 64'(bus.m_admin_r), 64'(ref_admin[a]));
    check({tag, "_lock"}, 64'(bus.m_lock_r), 64'(ref_lock[a]));
    check({tag, "_count"}, 64'(bus.m_count_r), 64'(ref_cnt[a]));
  endtask
  task automatic run(input bit dm, input bit df, input bit mwe, input logic [11:0] ma,
                     input logic [15:0] mp, input logic mad, input logic ml, input logic [3:0] mc,
                     input bit fclr, input logic [11:0] fa);
    int cyc = 0;
    int cs_n = 0;
    int m_at = 0;
    int f_at = 0;
    bit mseen = 1'b0;
    bit fseen = 1'b0;
    logic [3:0] ec;
    logic el;
    logic [7:0] rw_seq = '0;
    @(negedge clk);
    bus.m_req = dm; bus.m_we = mwe; bus.m_addr = ma; bus.m_pass_w = mp;
    bus.m_admin_w = mad; bus.m_lock_w = ml; bus.m_count_w = mc;
    bus.f_req = df; bus.f_clear = fclr; bus.f_addr = fa;
    while (((dm && !mseen) || (df && !fseen)) && cyc < 20) begin
      @(negedge clk);
      cyc++;
      check("m_done_spurious", 64'(bus.m_done && !(dm && !mseen)), 64'd0);
      check("f_done_spurious", 64'(bus.f_done && !(df && !fseen)), 64'd0);
      if (bus.cs) begin
        cs_n++;
        rw_seq = {rw_seq[3:0], bus.pass_rw, bus.admin_rw, bus.lock_rw, bus.count_rw};
      end
      if (bus.m_done && dm && !mseen) begin
        mseen = 1'b1;
        m_at = cyc;
        if (mwe) begin
          ref_pass[ma] = mp; ref_admin[ma] = mad; ref_lock[ma] = ml; ref_cnt[ma] = mc;
        end else check_read("m_read", ma);
        bus.m_req = 1'b0;
      end
      if (bus.f_done && df && !fseen) begin
        fseen = 1'b1;
        f_at = cyc;
        f_model(fclr, fa, ec, el);
        check("f_count", 64'(bus.f_count), 64'(ec));
        check("f_locked", 64'(bus.f_locked), 64'(el));
        bus.f_req = 1'b0;
      end
    end
    bus.m_req = 1'b0;
    bus.f_req = 1'b0;
    check("m_done_seen", 64'(mseen), 64'(dm));
    check("f_done_seen", 64'(fseen), 64'(df));
    if (dm && df) begin
      check("rr_manager_first", 64'(m_at < f_at), 64'(!last_m));
      last_m = m_at > f_at;
    end else if (dm) begin
      check("m_latency", 64'(m_at), 64'd2);
      check("m_cs_cycles", 64'(cs_n), 64'd1);
      check("m_rw", 64'(rw_seq[3:0]), mwe ? 64'hF : 64'h0);
      last_m = 1'b1;
    end else if (df) begin
      check("f_latency", 64'(f_at), 64'd3);
      check("f_cs_cycles", 64'(cs_n), 64'd2);
      check("f_rw", 64'(rw_seq), 64'h03);
      last_m = 1'b0;
    end
  endtask
  task automatic mfm(input logic [11:0] a);
    int cyc = 0;
    int n = 0;
    logic [5:0] seq = '0;
    logic [3:0] ec;
    logic el;
    @(negedge clk);
    bus.m_req = 1'b1; bus.m_we = 1'b0; bus.m_addr = a;
    bus.f_req = 1'b1; bus.f_clear = 1'b0; bus.f_addr = a;
    while (n < 3 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (bus.m_done) begin
        seq = {seq[3:0], 2'd1};
        n++;
        check_read("mfm_read", a);
        if (n == 3) bus.m_req = 1'b0;
      end
      if (bus.f_done) begin
        seq = {seq[3:0], 2'd2};
        n++;
        f_model(1'b0, a, ec, el);
        check("mfm_f_count", 64'(bus.f_count), 64'(ec));
        check("mfm_f_locked", 64'(bus.f_locked), 64'(el));
        bus.f_req = 1'b0;
      end
    end
    bus.m_req = 1'b0;
    bus.f_req = 1'b0;
    check("mfm_order", 64'(seq), 64'b01_10_01);
    repeat (6) @(negedge clk);
    last_m = 1'b1;
  endtask
  task automatic check_all_zero(input string tag);
    check({tag, "_req_side"}, 64'({bus.m_done, bus.m_pass_r, bus.m_admin_r, bus.m_lock_r,
          bus.m_count_r, bus.f_done, bus.f_locked, bus.f_count}), 64'd0);
    check({tag, "_ram_side"}, 64'({bus.cs, bus.pass_rw, bus.admin_rw, bus.lock_rw, bus.count_rw,
          bus.addr, bus.pass_in, bus.admin_in, bus.lock_in, bus.count_in}), 64'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    logic [11:0] a;
    logic [15:0] p;
    int kind;
    bus.m_req = 0; bus.m_we = 0; bus.m_addr = 0; bus.m_pass_w = 0; bus.m_admin_w = 0;
    bus.m_lock_w = 0; bus.m_count_w = 0; bus.f_req = 0; bus.f_clear = 0; bus.f_addr = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    run(1, 0, 1, 12'h001, 16'h1111, 1'b1, 1'b0, 4'd0, 0, 12'h0);
    run(1, 0, 0, 12'h001, 16'h0, 1'b0, 1'b0, 4'd0, 0, 12'h0);
    for (int i = 0; i < 3; i++) run(0, 1, 0, 12'h0, 16'h0, 1'b0, 1'b0, 4'd0, 0, 12'h002);
    run(1, 0, 1, 12'h003, 16'hA5A5, 1'b0, 1'b0, 4'd2, 0, 12'h0);
    run(0, 1, 0, 12'h0, 16'h0, 1'b0, 1'b0, 4'd0, 1, 12'h003);
    run(1, 0, 1, 12'h003, 16'hA5A5, 1'b0, 1'b1, 4'd5, 0, 12'h0);
    run(0, 1, 0, 12'h0, 16'h0, 1'b0, 1'b0, 4'd0, 1, 12'h003);
    run(1, 0, 1, 12'h004, 16'h4444, 1'b0, 1'b0, 4'd15, 0, 12'h0);
    run(0, 1, 0, 12'h0, 16'h0, 1'b0, 1'b0, 4'd0, 0, 12'h004);
    mfm(12'h002);
    @(negedge clk);
    bus.f_req = 1'b1; bus.f_clear = 1'b0; bus.f_addr = 12'h001;
    @(negedge clk);
    check("cut_frd_cs", 64'(bus.cs), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("cut_fwr_ctrl", 64'({bus.cs, bus.pass_rw, bus.admin_rw, bus.lock_rw, bus.count_rw}), 64'd0);
    bus.f_req = 1'b0;
    @(negedge clk);
    check_all_zero("cut");
    @(negedge clk);
    check("cut_no_f_done", 64'(bus.f_done), 64'd0);
    rst = 1'b1;
    last_m = 1'b0;
    run(1, 0, 0, 12'h001, 16'h0, 1'b0, 1'b0, 4'd0, 0, 12'h0);
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 4);
      a = 12'h020 + 12'($urandom_range(0, 3));
      p = 16'($urandom);
      case (kind)
        0: run(1, 0, 1, a, p, 1'($urandom), ($urandom_range(0, 3) == 0), 4'($urandom), 0, 12'h0);
        1: run(1, 0, 0, a, 16'h0, 1'b0, 1'b0, 4'd0, 0, 12'h0);
        2: run(0, 1, 0, 12'h0, 16'h0, 1'b0, 1'b0, 4'd0, 0, a);
        3: run(0, 1, 0, 12'h0, 16'h0, 1'b0, 1'b0, 4'd0, 1, a);
        default: run(1, 1, 1'($urandom), a, p, 1'($urandom), ($urandom_range(0, 3) == 0),
                     4'($urandom), 1'($urandom), 12'h020 + 12'($urandom_range(0, 3)));
      endcase
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
